// File: rtl/wallace_pkg.sv
// wallace_pkg: shared constants and elaboration-time helpers for the pipelined Wallace multiplier
//   PIPE_DEPTH  stages from input transfer to output valid
//   pp_rows     partial-product rows including the Baugh-Wooley correction row
//   bw_corr     Baugh-Wooley correction constant (2^W + 2^(2W-1)) for W-bit operands
//   rows_at     rows remaining after l levels of 3:2 reduction
//   csa_levels  3:2 levels needed to reach two rows
package wallace_pkg;
   localparam int PIPE_DEPTH = 3;
   function automatic int pp_rows(input int w);
      return w + 1;
   endfunction
   function automatic logic [63:0] bw_corr(input int w);
      return (64'd1 << w) | (64'd1 << (2 * w - 1));
   endfunction
   function automatic int csa_next(input int n);
      return n - n / 3;
   endfunction
   function automatic int rows_at(input int n, input int l);
      int r;
      r = n;
      for (int i = 0; i < l; i++) r = csa_next(r);
      return r;
   endfunction
   function automatic int csa_levels(input int n);
      int r;
      int l;
      r = n;
      l = 0;
      while (r > 2) begin
         r = csa_next(r);
         l++;
      end
      return l;
   endfunction
endpackage

// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: operand/product valid-ready bus of the pipelined multiplier
//   in_*  operand beat (valid, ready, a, b, signed mode, tag) from producer
//   out_* product beat (valid, ready, product, tag) to consumer
//   master = producer/consumer side, slave = multiplier side
interface wallace_mult_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_prod;
   logic [TAG_W-1:0]   out_tag;
   modport master (
      output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_prod, out_tag
   );
   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      output in_ready, out_valid, out_prod, out_tag
   );
endinterface

// File: rtl/wallace_csa_row.sv
// wallace_csa_row: N-bit row of 3:2 compressors
//   a_i, b_i, c_i  three addend vectors
//   sum_o          bitwise sum
//   carry_o        majority carries already shifted to their weight (top carry drops out)
module wallace_csa_row #(
   parameter int N = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] c_i,
   output logic [N-1:0] sum_o,
   output logic [N-1:0] carry_o
);
   logic [N-1:0] maj;
   assign sum_o   = a_i ^ b_i ^ c_i;
   assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
   assign carry_o = maj << 1;
endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage Wallace-tree multiplier, signed/unsigned per beat, valid/ready
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of wallace_mult_pipe_if (operand beat in, product beat out)
module wallace_mult_pipe
   import wallace_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input logic clk,
   input logic rst,
   wallace_mult_pipe_if.slave bus
);
   localparam int P    = 2 * WIDTH;
   localparam int ROWS = pp_rows(WIDTH);
   localparam int LVLS = csa_levels(ROWS);
   localparam logic [63:0] CORR = bw_corr(WIDTH);

   logic             v1_q, v2_q, v3_q;
   logic             en1, en2, en3;
   logic [WIDTH-1:0] a1_q, b1_q;
   logic             s1_q;
   logic [TAG_W-1:0] t1_q, t2_q, t3_q;
   logic [P-1:0]     sum_d, car_d, sum2_q, car2_q, prod_d, prod3_q;
   logic [P-1:0]     pp [ROWS];
   logic [P-1:0]     tree [LVLS+1][ROWS];

   // each stage advances when it is empty or its successor advances
   assign en3 = !v3_q || bus.out_ready;
   assign en2 = !v2_q || en3;
   assign en1 = !v1_q || en2;

   // Baugh-Wooley: invert the terms pairing exactly one operand MSB, then add the correction row
   always_comb begin
      for (int i = 0; i < ROWS; i++) pp[i] = '0;
      for (int i = 0; i < WIDTH; i++)
         for (int j = 0; j < WIDTH; j++)
            pp[i][i+j] = (a1_q[j] & b1_q[i]) ^ (s1_q && ((i == WIDTH - 1) != (j == WIDTH - 1)));
      pp[WIDTH] = s1_q ? CORR[P-1:0] : '0;
   end

   for (genvar k = 0; k < ROWS; k++) begin : g_lvl0
      assign tree[0][k] = pp[k];
   end

   // each level compresses every full group of three rows; leftover rows pass straight through
   for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      localparam int N = rows_at(ROWS, l);
      localparam int G = N / 3;
      localparam int M = rows_at(ROWS, l + 1);
      for (genvar g = 0; g < G; g++) begin : g_csa
         wallace_csa_row #(.N(P)) u_csa (
            .a_i    (tree[l][3*g]),
            .b_i    (tree[l][3*g+1]),
            .c_i    (tree[l][3*g+2]),
            .sum_o  (tree[l+1][2*g]),
            .carry_o(tree[l+1][2*g+1])
         );
      end
      for (genvar r = 0; r < N - 3 * G; r++) begin : g_pass
         assign tree[l+1][2*G+r] = tree[l][3*G+r];
      end
      for (genvar k = M; k < ROWS; k++) begin : g_zero
         assign tree[l+1][k] = '0;
      end
   end

   assign sum_d  = tree[LVLS][0];
   assign car_d  = tree[LVLS][1];
   assign prod_d = sum2_q + car2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         prod3_q <= '0;
         t3_q    <= '0;
      end else begin
         if (en1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
               a1_q <= bus.in_a;
               b1_q <= bus.in_b;
               s1_q <= bus.in_signed;
               t1_q <= bus.in_tag;
            end
         end
         if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               sum2_q <= sum_d;
               car2_q <= car_d;
               t2_q   <= t1_q;
            end
         end
         if (en3) begin
            v3_q <= v2_q;
            if (v2_q) begin
               prod3_q <= prod_d;
               t3_q    <= t2_q;
            end
         end
      end
   end

   assign bus.in_ready  = en1;
   assign bus.out_valid = v3_q;
   assign bus.out_prod  = prod3_q;
   assign bus.out_tag   = t3_q;
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed bench for WIDTH=8 flow control/corners and exhaustive WIDTH=4 products
//   drives two DUT instances through wallace_mult_pipe_if and scoreboards every product beat
module tb_wallace_mult_pipe;
   typedef struct {
      int         cyc;
      logic [3:0] tag;
      logic [15:0] prod;
   } exp8_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   outs8 = 0;
   int   outs4 = 0;
   bit   lat_on = 0;
   logic [15:0] nxt_prod;
   logic [7:0]  nxt4;
   exp8_t       q8[$];
   logic [7:0]  q4[$];

   wallace_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) b8();
   wallace_mult_pipe_if #(.WIDTH(4), .TAG_W(4)) b4();

   wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   wallace_mult_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         q4.delete();
      end else begin
         if (b8.in_valid && b8.in_ready) q8.push_back('{cyc, b8.in_tag, nxt_prod});
         if (b8.out_valid && b8.out_ready) begin
            outs8++;
            if (q8.size() == 0) chk("spurious_out8", b8.out_valid, 0);
            else begin
               automatic exp8_t e = q8.pop_front();
               chk("prod8", b8.out_prod, e.prod);
               chk("tag8", b8.out_tag, e.tag);
               if (lat_on) chk("latency8", cyc - e.cyc, 3);
            end
         end
         if (b4.in_valid && b4.in_ready) q4.push_back(nxt4);
         if (b4.out_valid && b4.out_ready) begin
            outs4++;
            if (q4.size() == 0) chk("spurious_out4", b4.out_valid, 0);
            else chk("prod4", b4.out_prod, q4.pop_front());
         end
      end
   end

   // present one beat and hold it until accepted; w returns the cycles spent waiting
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic [15:0] e, output int w);
      w = 0;
      b8.in_valid  = 1;
      b8.in_a      = a;
      b8.in_b      = b;
      b8.in_signed = s;
      b8.in_tag    = t;
      nxt_prod     = e;
      @(negedge clk);
      while (!b8.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) chk("accept_timeout", b8.in_ready, 1);
      @(posedge clk);
      #1;
      b8.in_valid = 0;
   endtask

   task automatic set_bp(input int k);
      b8.in_a      = 8'(k + 2);
      b8.in_b      = 8'd3;
      b8.in_signed = 0;
      b8.in_tag    = 4'(k);
      nxt_prod     = 16'((k + 2) * 3);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      int acc;
      int o0;
      rst = 1;
      b8.in_valid = 0; b8.in_a = 0; b8.in_b = 0; b8.in_signed = 0; b8.in_tag = 0; b8.out_ready = 1;
      b4.in_valid = 0; b4.in_a = 0; b4.in_b = 0; b4.in_signed = 0; b4.in_tag = 0; b4.out_ready = 1;
      nxt_prod = 0;
      nxt4 = 0;
      wait_cyc(2);
      chk("rst_out_valid", b8.out_valid, 0);
      chk("rst_out_prod", b8.out_prod, 0);
      chk("rst_out_tag", b8.out_tag, 0);
      rst = 0;
      #1;
      chk("post_rst_in_ready", b8.in_ready, 1);

      lat_on = 1;
      send(8'd255, 8'd255, 0, 4'd1, 16'hFE01, w);
      send(8'h80, 8'h80, 1, 4'd2, 16'h4000, w);
      send(8'hFF, 8'h01, 1, 4'd3, 16'hFFFF, w);
      send(8'h7F, 8'h80, 1, 4'd4, 16'hC080, w);
      send(8'd0, 8'd200, 0, 4'd5, 16'h0000, w);
      wait_cyc(6);
      chk("corner_drain", q8.size(), 0);
      chk("corner_count", outs8, 5);

      lat_on = 0;
      b8.out_ready = 0;
      acc = 0;
      b8.in_valid = 1;
      set_bp(acc);
      repeat (6) begin
         @(negedge clk);
         if (b8.in_ready) acc++;
         @(posedge clk);
         #1;
         set_bp(acc);
      end
      chk("bp_accepted", acc, 3);
      chk("bp_in_ready", b8.in_ready, 0);
      chk("bp_out_valid", b8.out_valid, 1);
      chk("bp_out_prod", b8.out_prod, 16'd6);
      chk("bp_out_tag", b8.out_tag, 0);
      wait_cyc(1);
      chk("bp_hold_prod", b8.out_prod, 16'd6);
      b8.out_ready = 1;
      b8.in_valid = 0;
      #1;
      chk("bp_release_ready", b8.in_ready, 1);
      o0 = outs8;
      wait_cyc(3);
      chk("bp_drain_count", outs8 - o0, 3);
      chk("bp_drain_empty", q8.size(), 0);

      send(8'd10, 8'd20, 0, 4'd5, 16'h00C8, w);
      wait_cyc(1);
      send(8'hFD, 8'h07, 1, 4'd6, 16'hFFEB, w);
      b8.out_ready = 0;
      send(8'd12, 8'd12, 0, 4'd7, 16'h0090, w);
      chk("bub_c_wait", w, 0);
      chk("bub_a_valid", b8.out_valid, 1);
      chk("bub_a_tag", b8.out_tag, 5);
      chk("bub_a_prod", b8.out_prod, 16'h00C8);
      b8.out_ready = 1;
      wait_cyc(5);
      chk("bub_drain_empty", q8.size(), 0);

      lat_on = 1;
      send(8'd3, 8'd3, 0, 4'd1, 16'd9, w);
      send(8'd4, 8'd4, 0, 4'd2, 16'd16, w);
      send(8'd5, 8'd5, 0, 4'd3, 16'd25, w);
      rst = 1;
      wait_cyc(1);
      rst = 0;
      chk("mrst_out_valid", b8.out_valid, 0);
      chk("mrst_out_prod", b8.out_prod, 0);
      o0 = outs8;
      wait_cyc(5);
      chk("mrst_no_stale", outs8 - o0, 0);
      send(8'd9, 8'd9, 0, 4'd9, 16'h0051, w);
      wait_cyc(5);
      chk("mrst_new_count", outs8 - o0, 1);

      for (int k = 0; k < 4; k++) send(8'hF0, 8'h0F, k[0], 4'(k), k[0] ? 16'hFF10 : 16'h0E10, w);
      wait_cyc(6);
      chk("mode_drain_empty", q8.size(), 0);
      lat_on = 0;

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               automatic logic [3:0] a4 = 4'(a);
               automatic logic [3:0] bb = 4'(b);
               b4.in_valid  = 1;
               b4.in_a      = a4;
               b4.in_b      = bb;
               b4.in_signed = s[0];
               b4.in_tag    = a4;
               nxt4 = s[0] ? 8'($signed({{4{a4[3]}}, a4}) * $signed({{4{bb[3]}}, bb}))
                           : {4'b0, a4} * {4'b0, bb};
               wait_cyc(1);
            end
      b4.in_valid = 0;
      wait_cyc(6);
      chk("exh_count", outs4, 512);
      chk("exh_empty", q4.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier. It is the successor to the team's fixed 4x4 combinational Wallace multiplier.
- Adds configurable operand width, per-transaction signed/unsigned mode, a 3-stage pipeline and valid/ready flow control with backpressure.
- Sits between operand producers and the accumulate/datapath units. One product per cycle when not stalled.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 4..32.
- TAG_W, 4, width of the opaque user tag carried alongside each operation.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  input  TAG_W  user tag, returned unchanged with the product.
- out_valid  output  1  product beat valid.
- out_ready  input  1  consumer accepts product this cycle.
- out_prod  output  2*WIDTH  full-width product.
- out_tag  output  TAG_W  tag of the returned product.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage S1: register operands, mode and tag; form WIDTH partial-product rows.
  - Unsigned: plain AND array.
  - Signed: Baugh-Wooley inversion of MSB terms, with correction constants added as an extra row.
- Stage S2: Wallace reduction of all rows to two rows (sum, carry) using 3:2 and 2:2 compressors, layered as a true Wallace tree; register both rows.
- Stage S3: final carry-propagate add, truncated to 2*WIDTH bits; register into out_prod.
- Latency: exactly 3 cycles from input transfer to out_valid, with no stalls.
- Each stage Sk has a valid bit vk. Stage enables:
  - en3 = !v3 || out_ready
  - en2 = !v2 || en3
  - en1 = !v1 || en2
  - in_ready = en1 (combinational chain; no in_valid -> in_ready path).
- Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled. Capacity is 3 beats.
- When a stage is not enabled it holds its data and valid bit.
- Tag and mode bits travel with their stage data; products are never reordered.
- Output stability: out_prod and out_tag hold stable while out_valid && !out_ready.
- Reset: v1, v2 and v3 clear to 0, so out_valid = 0.
  - out_prod and out_tag reset to 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats; no partial product is ever emitted.
- A beat presented during the reset cycle is not accepted.
- Arithmetic is exact: the signed product of WIDTH-bit operands fits in 2*WIDTH bits, including the corner case MIN*MIN. No overflow flag.
- Mode is sampled per beat, so back-to-back beats may alternate signed and unsigned.

Decomposition:
- Shared package wallace_pkg:
  - function pp_rows(WIDTH): number of partial-product rows, WIDTH+1 in signed-capable form.
  - localparam PIPE_DEPTH = 3.
  - Baugh-Wooley correction-constant function.
- Sub-module wallace_csa_row: parametrised row of 3:2 compressors (three N-bit vectors to sum and carry). Instantiated per tree level by generate loops in S2.

Test Plan:
- WIDTH=4, exhaustive: all 256 (a,b) pairs in both modes, out_ready held 1.
  - Every out_prod matches the reference model (unsigned a*b; signed $signed(a)*$signed(b) over 8 bits).
  - Error counter ends at 0; output count is 512.
- WIDTH=8 corners:
  - unsigned 255*255 -> 0xFE01
  - signed -128*-128 -> 0x4000
  - signed -1*1 -> 0xFFFF
  - signed 127*-128 -> 0xC080
  - unsigned 0*200 -> 0x0000
  - Each appears 3 cycles after acceptance, in order, with the matching tag.
- Backpressure:
  - Hold out_ready=0 and drive in_valid=1 continuously.
  - Exactly 3 beats are accepted, then in_ready=0 and out_prod holds stable.
  - Release out_ready: the products drain in order, one per cycle, and in_ready rises in the same cycle.
- Bubble collapse:
  - Issue beats A, idle, B; stall out_ready while A is in S3.
  - B advances to S2 and an input beat is still accepted; the order A, B, C is preserved.
- Mid-operation reset:
  - With 3 beats in flight, assert rst for 1 cycle.
  - The next cycle has out_valid=0 and out_prod=0; no stale product ever appears; a new beat returns correctly 3 cycles later.
- Mode interleave: alternate signed and unsigned every cycle with a=0xF0, b=0x0F.
  - Results alternate 0x0E10 (unsigned) and 0xFF10 (signed, -16*15).
